// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: expands the 256-bit cipher key into 60 words, one per clock,
// and serves the 15 round keys through a registered, indexed read port.

module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] result
);
    // Forward AES S-box, entry 0x00 in the most significant byte of the table
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    // Entry b starts at bit 8*(255-b), which is 8*~b
    assign result = SBOX_TABLE[{~data, 3'b000} +: 8];
endmodule

module aes256_key_expand #(
    parameter int NR = 14
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [255:0] key_i,
    output logic         busy_o,
    output logic         keys_valid_o,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o
);
    localparam int         NWORDS    = 4 * (NR + 1);
    localparam logic [5:0] LAST_WORD = 6'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  word_cnt;
    logic [31:0] w [NWORDS];
    logic        start_acc;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp_word;
    logic [31:0] new_word;
    logic [7:0]  rcon;

    // A start is honoured whenever no expansion is running
    assign start_acc    = start_i && (state != EXPAND);
    assign busy_o       = (state == EXPAND);
    assign keys_valid_o = (state == DONE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = EXPAND;
            EXPAND:  if (word_cnt == LAST_WORD) state_next = DONE;
            DONE:    if (start_i) state_next = EXPAND;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            word_cnt <= '0;
        end else if (start_acc) begin
            word_cnt <= 6'd8;
        end else if (state == EXPAND) begin
            word_cnt <= word_cnt + 6'd1;
        end
    end

    always_comb begin
        rcon = 8'h00;
        case (word_cnt[5:3])
            3'd1:    rcon = 8'h01;
            3'd2:    rcon = 8'h02;
            3'd3:    rcon = 8'h04;
            3'd4:    rcon = 8'h08;
            3'd5:    rcon = 8'h10;
            3'd6:    rcon = 8'h20;
            3'd7:    rcon = 8'h40;
            default: rcon = 8'h00;
        endcase
    end

    assign prev_word = w[word_cnt - 6'd1];
    assign back_word = w[word_cnt - 6'd8];

    // RotWord only feeds the S-boxes on the Rcon steps
    assign sub_in = (word_cnt[2:0] == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data   (sub_in[8*b +: 8]),
            .result (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp_word = prev_word;
        case (word_cnt[2:0])
            3'd0:    temp_word = sub_out ^ {rcon, 24'h000000};
            3'd4:    temp_word = sub_out;
            default: temp_word = prev_word;
        endcase
    end

    assign new_word = back_word ^ temp_word;

    // The word store is never reset; its contents only matter once keys_valid_o is high
    always_ff @(posedge clk_i) begin
        if (start_acc) begin
            for (int k = 0; k < 8; k++) begin
                w[k] <= key_i[255 - 32*k -: 32];
            end
        end else if (state == EXPAND) begin
            w[word_cnt] <= new_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rk_o <= '0;
        end else if (rk_idx_i > 4'(NR)) begin
            rk_o <= '0;
        end else begin
            rk_o <= {w[{rk_idx_i, 2'b00}], w[{rk_idx_i, 2'b01}],
                     w[{rk_idx_i, 2'b10}], w[{rk_idx_i, 2'b11}]};
        end
    end
endmodule

// File: tb/tb_aes256_key_expand.sv
// Bench for aes256_key_expand: a GF(2^8)-derived key schedule model checked every cycle,
// plus directed FIPS-197 and zero-key vectors with literal expectations.

module tb_aes256_key_expand;
    logic         clk_i    = 1'b0;
    logic         rst_i    = 1'b1;
    logic         start_i  = 1'b0;
    logic [255:0] key_i    = '0;
    logic [3:0]   rk_idx_i = 4'd0;
    logic         busy_o;
    logic         keys_valid_o;
    logic [127:0] rk_o;

    localparam logic [255:0] KEY_A3 =
        256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    typedef logic [14:0][127:0] rk_set_t;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        cmp_en       = 1'b0;
    logic [7:0]  sbox_tab [256];
    rk_set_t     exp_a3;
    rk_set_t     exp_zero;
    rk_set_t     pin_set;

    // Behavioural model state, advanced on the same edges the DUT sees
    logic        m_busy  = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_rk_ok = 1'b1;
    logic [127:0] m_rk   = '0;
    int          m_cnt   = 0;
    rk_set_t     m_keys  = '0;
    rk_set_t     m_pend  = '0;

    aes256_key_expand dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .key_i        (key_i),
        .busy_o       (busy_o),
        .keys_valid_o (keys_valid_o),
        .rk_idx_i     (rk_idx_i),
        .rk_o         (rk_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] xtime(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotb(logic [7:0] b, int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map
    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotb(inv, 1) ^ rotb(inv, 2) ^ rotb(inv, 3) ^ rotb(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWord(logic [31:0] v);
        return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
    endfunction

    function automatic rk_set_t expandKey(logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_set_t     rs;
        for (int k = 0; k < 8; k++) w[k] = key[255 - 32*k -: 32];
        for (int k = 8; k < 60; k++) begin
            t = w[k-1];
            if (k % 8 == 0) begin
                rc = 8'h01;
                for (int j = 1; j < k / 8; j++) rc = xtime(rc);
                t = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (k % 8 == 4) begin
                t = subWord(t);
            end
            w[k] = w[k-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rs[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rs;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [255:0] key, input logic [3:0] idx);
        start_i  = start;
        key_i    = key;
        rk_idx_i = idx;
        @(negedge clk_i);
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (keys_valid_o !== 1'b1 && n < 70) begin
            applyStimulus(1'b0, key_i, rk_idx_i);
            n++;
        end
    endtask

    task automatic readKey(input logic [3:0] idx, input logic [127:0] expected, input string name);
        applyStimulus(1'b0, key_i, idx);
        checkOutput(name, rk_o, expected);
    endtask

    // Timing model: acceptance when not busy, completion 52 edges later
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_rk    <= '0;
            m_rk_ok <= 1'b1;
        end else begin
            m_rk_ok <= m_valid || (rk_idx_i > 4'd14);
            m_rk    <= (rk_idx_i > 4'd14) ? 128'h0 : m_keys[rk_idx_i];
            if (start_i && !m_busy) begin
                m_pend  <= expandKey(key_i);
                m_busy  <= 1'b1;
                m_valid <= 1'b0;
                m_cnt   <= 0;
            end else if (m_busy) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 51) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_keys  <= m_pend;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en && rst_i) begin
            checkOutput("cmp_busy", 128'(busy_o), 128'(m_busy));
            checkOutput("cmp_valid", 128'(keys_valid_o), 128'(m_valid));
            if (m_rk_ok) checkOutput("cmp_rk", rk_o, m_rk);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        buildSbox();
        exp_a3   = expandKey(KEY_A3);
        exp_zero = expandKey(256'h0);

        #1 rst_i = 1'b0;
        #1;
        checkOutput("reset_busy", 128'(busy_o), 128'h0);
        checkOutput("reset_valid", 128'(keys_valid_o), 128'h0);
        checkOutput("reset_rk", rk_o, 128'h0);
        repeat (2) @(negedge clk_i);
        rst_i  = 1'b1;
        cmp_en = 1'b1;

        // Pin the model to known published values
        checkOutput("model_sbox_00", 128'(sbox_tab[8'h00]), 128'h63);
        checkOutput("model_sbox_53", 128'(sbox_tab[8'h53]), 128'hed);
        pin_set = exp_a3;
        checkOutput("model_a3_rk2", pin_set[2], 128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
        checkOutput("model_a3_rk14", pin_set[14], 128'hfe4890d1_e6188d0b_046df344_706c631e);
        pin_set = exp_zero;
        checkOutput("model_zero_rk3", pin_set[3], {4{32'haafbfbfb}});

        $display("[TB] test 1: FIPS-197 A.3 key");
        applyStimulus(1'b1, KEY_A3, 4'd0);
        checkOutput("t1_busy_after_start", 128'(busy_o), 128'h1);
        waitValid(n);
        checkOutput("t1_latency", 128'(n), 128'd52);
        readKey(4'd0,  128'h603deb10_15ca71be_2b73aef0_857d7781, "t1_rk0");
        readKey(4'd1,  128'h1f352c07_3b6108d7_2d9810a3_0914dff4, "t1_rk1");
        readKey(4'd2,  128'h9ba35411_8e6925af_a51a8b5f_2067fcde, "t1_rk2");
        readKey(4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e, "t1_rk14");

        $display("[TB] test 2/5: zero key started from DONE");
        applyStimulus(1'b1, 256'h0, 4'd0);
        checkOutput("t5_valid_falls", 128'(keys_valid_o), 128'h0);
        checkOutput("t5_busy_rises", 128'(busy_o), 128'h1);
        waitValid(n);
        checkOutput("t5_latency", 128'(n), 128'd52);
        readKey(4'd2,  {4{32'h62636363}}, "t2_rk2");
        readKey(4'd3,  {4{32'haafbfbfb}}, "t2_rk3");
        readKey(4'd15, 128'h0, "t2_rk15");

        $display("[TB] test 3: start during expansion is ignored");
        applyStimulus(1'b1, KEY_A3, 4'd0);
        n = 0;
        while (keys_valid_o !== 1'b1 && n < 70) begin
            n++;
            applyStimulus(1'(n == 20), 256'h0, 4'd0);
            if (n == 20) checkOutput("t3_busy_kept", 128'(busy_o), 128'h1);
        end
        checkOutput("t3_latency", 128'(n), 128'd52);
        readKey(4'd0,  128'h603deb10_15ca71be_2b73aef0_857d7781, "t3_rk0");
        readKey(4'd2,  128'h9ba35411_8e6925af_a51a8b5f_2067fcde, "t3_rk2");
        readKey(4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e, "t3_rk14");

        $display("[TB] test 4: asynchronous reset mid-expansion");
        applyStimulus(1'b1, KEY_A3, 4'd0);
        repeat (30) applyStimulus(1'b0, KEY_A3, 4'd0);
        #2 rst_i = 1'b0;
        #1;
        checkOutput("t4_busy_async", 128'(busy_o), 128'h0);
        checkOutput("t4_valid_async", 128'(keys_valid_o), 128'h0);
        checkOutput("t4_rk_async", rk_o, 128'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        applyStimulus(1'b0, KEY_A3, 4'd0);
        checkOutput("t4_idle_busy", 128'(busy_o), 128'h0);
        checkOutput("t4_idle_valid", 128'(keys_valid_o), 128'h0);
        applyStimulus(1'b1, KEY_A3, 4'd0);
        waitValid(n);
        checkOutput("t4_latency", 128'(n), 128'd52);
        readKey(4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e, "t4_rk14");
        readKey(4'd2,  128'h9ba35411_8e6925af_a51a8b5f_2067fcde, "t4_rk2");

        $display("[TB] test 6: one-cycle read latency sweep");
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, KEY_A3, 4'(k));
            checkOutput($sformatf("t6_rk%0d", k), rk_o, exp_a3[k]);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
